// File: rtl/onchip_stream_writer.sv
// Packs an 8-bit stream into little-endian 32-bit words and writes them to an on-chip RAM port.
// Optional running checksum of written words: define ONCHIP_STREAM_WRITER_CHECKSUM_EN.
module onchip_stream_writer #(
  parameter int DEPTH  = 12000,
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [7:0]        snk_data_i,
  input  logic              snk_valid_i,
  input  logic              snk_eop_i,
  output logic              snk_ready_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [3:0]        mem_byteenable_o,
  output logic              mem_chipselect_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_writedata_o,
  output logic              mem_clken_o,
  output logic              busy_o,
  output logic              done_o,
`ifdef ONCHIP_STREAM_WRITER_CHECKSUM_EN
  output logic [31:0]       checksum_o,
`endif
  output logic [ADDR_W:0]   word_count_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Reset asserts asynchronously but is released only after two clean edges.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        k_q, k_d;
  logic [31:0]       pack_q, pack_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic              last_q, last_d;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      k_q     <= '0;
      pack_q  <= '0;
      wc_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      k_q     <= k_d;
      pack_q  <= pack_d;
      wc_q    <= wc_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    k_d     = k_q;
    pack_d  = pack_q;
    wc_d    = wc_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = PACK;
          addr_d  = base_addr_i;
          k_d     = '0;
          pack_d  = '0;
          wc_d    = '0;
          last_d  = 1'b0;
        end
      end
      PACK: begin
        if (snk_valid_i) begin
          pack_d[{k_q[1:0], 3'b000} +: 8] = snk_data_i;
          k_d    = k_q + 3'd1;
          last_d = snk_eop_i;
          if (k_q == 3'd3 || snk_eop_i) state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d  = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
        wc_d    = wc_q + 1'b1;
        k_d     = '0;
        // Clearing here keeps unfilled lanes of the next word at zero.
        pack_d  = '0;
        state_d = last_q ? DONE : PACK;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic write_cyc;
  assign write_cyc = (state_q == WRITE);

  // Lane gi is enabled when at least gi+1 bytes were packed into the word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_be
    assign mem_byteenable_o[gi] = write_cyc && (k_q > 3'(gi));
  end

  assign snk_ready_o      = (state_q == PACK);
  assign mem_address_o    = addr_q;
  assign mem_chipselect_o = write_cyc;
  assign mem_write_o      = write_cyc;
  assign mem_writedata_o  = write_cyc ? pack_q : 32'd0;
  assign mem_clken_o      = 1'b1;
  assign busy_o           = (state_q == PACK) || (state_q == WRITE);
  assign done_o           = (state_q == DONE);
  assign word_count_o     = wc_q;

`ifdef ONCHIP_STREAM_WRITER_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == IDLE && start_i) checksum_d = '0;
    else if (write_cyc)             checksum_d = checksum_q + pack_q;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) checksum_q <= '0;
    else        checksum_q <= checksum_d;
  end

  assign checksum_o = checksum_q;
`endif

endmodule

// File: tb/tb_onchip_stream_writer.sv
// Scoreboard bench: stimulus pushes hand-computed writes/word counts, a monitor pops and compares.
module tb_onchip_stream_writer;
  localparam int DEPTH  = 12000;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [7:0]        snk_data = '0;
  logic              snk_valid = 1'b0;
  logic              snk_eop = 1'b0;
  logic              snk_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken, busy, done;
  logic [31:0]       mem_writedata;
  logic [ADDR_W:0]   word_count;
`ifdef ONCHIP_STREAM_WRITER_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  onchip_stream_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .base_addr_i(base_addr),
    .snk_data_i(snk_data), .snk_valid_i(snk_valid), .snk_eop_i(snk_eop),
    .snk_ready_o(snk_ready), .mem_address_o(mem_address), .mem_byteenable_o(mem_byteenable),
    .mem_chipselect_o(mem_chipselect), .mem_write_o(mem_write), .mem_writedata_o(mem_writedata),
    .mem_clken_o(mem_clken), .busy_o(busy), .done_o(done),
`ifdef ONCHIP_STREAM_WRITER_CHECKSUM_EN
    .checksum_o(checksum),
`endif
    .word_count_o(word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
  } wr_t;

  wr_t             exp_wr[$];
  logic [ADDR_W:0] exp_wc[$];
  int              checks = 0;
  int              errors = 0;
  logic [7:0]      pkt[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] b);
    wr_t w;
    w.addr = a; w.data = d; w.be = b;
    exp_wr.push_back(w);
  endtask

  // Monitor: every write and every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (mem_write) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_write", {18'd0, mem_address, mem_writedata}, 64'd0);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        $display("write addr=0x%0h data=0x%08h be=%b", mem_address, mem_writedata, mem_byteenable);
        chk("wr_addr", 64'(mem_address), 64'(w.addr));
        chk("wr_data", 64'(mem_writedata), 64'(w.data));
        chk("wr_be", 64'(mem_byteenable), 64'(w.be));
        chk("wr_cs", 64'(mem_chipselect), 64'd1);
      end
    end else if (mem_chipselect) begin
      chk("cs_without_write", 64'(mem_chipselect), 64'd0);
    end
    if (done) begin
      if (exp_wc.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        logic [ADDR_W:0] wc;
        wc = exp_wc.pop_front();
        $display("done word_count=%0d", word_count);
        chk("done_word_count", 64'(word_count), 64'(wc));
        chk("done_busy_low", 64'(busy), 64'd0);
      end
    end
  end

  task automatic send_packet(input logic [ADDR_W-1:0] base, input int len,
                             input bit gaps, input bit restart);
    int idx = 0;
    int guard = 0;
    // start arrives together with a valid byte; that byte must not be taken.
    @(negedge clk);
    start = 1'b1; base_addr = base; snk_valid = 1'b1; snk_data = 8'hEE; snk_eop = 1'b1;
    @(negedge clk);
    start = 1'b0; base_addr = 14'h0200;
    while (idx < len && guard < 1000) begin
      guard++;
      start = (restart && idx == 3);
      if (gaps && $urandom_range(0, 2) == 0) begin
        snk_valid = 1'b0;
      end else begin
        snk_valid = 1'b1; snk_data = pkt[idx]; snk_eop = (idx == len - 1);
      end
      if (snk_valid && snk_ready) idx++;
      @(negedge clk);
    end
    snk_valid = 1'b0; snk_eop = 1'b0; start = 1'b0;
    if (guard >= 1000) chk("packet_timeout", 64'(idx), 64'(len));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("done_timeout", 64'(done), 64'd1);
    @(negedge clk);
    chk("idle_after_done_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outputs", 64'({snk_ready, mem_chipselect, mem_write, busy, done}), 64'd0);
    chk("rst_data", 64'({mem_writedata, mem_byteenable}), 64'd0);
    chk("rst_addr_wc", 64'({mem_address, word_count}), 64'd0);
    chk("rst_clken", 64'(mem_clken), 64'd1);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", 64'({snk_ready, busy}), 64'd0);

    // Single aligned word
    pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33; pkt[3] = 8'h44;
    push_wr(14'h0010, 32'h44332211, 4'hF);
    exp_wc.push_back(15'd1);
    send_packet(14'h0010, 4, 1'b0, 1'b0);
    wait_done();
    chk("wc_holds_after_done", 64'(word_count), 64'd1);

    // Six bytes: full word then a two-lane word
    for (int i = 0; i < 6; i++) pkt[i] = 8'(i + 1);
    push_wr(14'h0000, 32'h04030201, 4'hF);
    push_wr(14'h0001, 32'h00000605, 4'h3);
    exp_wc.push_back(15'd2);
    send_packet(14'h0000, 6, 1'b0, 1'b0);
    wait_done();
`ifdef ONCHIP_STREAM_WRITER_CHECKSUM_EN
    chk("checksum", 64'(checksum), 64'h04030806);
`endif

    // Address wrap from DEPTH-1
    for (int i = 0; i < 8; i++) pkt[i] = 8'(8'hA0 + i);
    push_wr(14'(DEPTH - 1), 32'hA3A2A1A0, 4'hF);
    push_wr(14'h0000, 32'hA7A6A5A4, 4'hF);
    exp_wc.push_back(15'd2);
    send_packet(14'(DEPTH - 1), 8, 1'b0, 1'b0);
    wait_done();

    // Three-byte tail packet
    pkt[0] = 8'h5A; pkt[1] = 8'hC3; pkt[2] = 8'h7E;
    push_wr(14'h0123, 32'h007EC35A, 4'h7);
    exp_wc.push_back(15'd1);
    send_packet(14'h0123, 3, 1'b0, 1'b0);
    wait_done();

    // Reset mid-packet: two bytes in, nothing may be written
    @(negedge clk);
    start = 1'b1; base_addr = 14'h0040;
    @(negedge clk);
    start = 1'b0; snk_valid = 1'b1; snk_data = 8'h99; snk_eop = 1'b0;
    repeat (2) @(negedge clk);
    snk_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_wc", 64'(word_count), 64'd0);
    chk("midrst_ready", 64'(snk_ready), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33; pkt[3] = 8'h44;
    push_wr(14'h0020, 32'h44332211, 4'hF);
    exp_wc.push_back(15'd1);
    send_packet(14'h0020, 4, 1'b0, 1'b0);
    wait_done();

    // Gapped valid with a start re-pulse mid-packet that must be ignored
    for (int i = 0; i < 6; i++) pkt[i] = 8'(i + 1);
    push_wr(14'h0100, 32'h04030201, 4'hF);
    push_wr(14'h0101, 32'h00000605, 4'h3);
    exp_wc.push_back(15'd2);
    send_packet(14'h0100, 6, 1'b1, 1'b1);
    wait_done();

    repeat (5) @(negedge clk);
    chk("writes_outstanding", 64'(exp_wr.size()), 64'd0);
    chk("dones_outstanding", 64'(exp_wc.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onchip_stream_writer.md
ONCHIP_STREAM_WRITER -- requirements
Module: onchip_stream_writer

Interface
REQ-001 Parameter DEPTH, default 12000, words in the downstream on-chip RAM; address wrap limit.
REQ-002 Parameter ADDR_W, default 14, word-address width of the downstream RAM.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a packet capture at base_addr.
REQ-006 base_addr  input  ADDR_W  first word address, sampled on accepted start.
REQ-007 snk_data  input  8  streaming byte.
REQ-008 snk_valid  input  1  snk_data valid.
REQ-009 snk_eop  input  1  marks the last byte of the packet; qualified by snk_valid.
REQ-010 snk_ready  output  1  byte accepted when snk_valid and snk_ready are both high.
REQ-011 mem_address  output  ADDR_W  RAM word address.
REQ-012 mem_byteenable  output  4  RAM byte lanes.
REQ-013 mem_chipselect  output  1  RAM select.
REQ-014 mem_write  output  1  RAM write strobe.
REQ-015 mem_writedata  output  32  RAM write data.
REQ-016 mem_clken  output  1  RAM clock enable.
REQ-017 busy  output  1  high from accepted start until the cycle done pulses.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 word_count  output  ADDR_W+1  words written in the current or last packet.

Function
REQ-020 The FSM SHALL have states IDLE, PACK, WRITE, and DONE.
REQ-021 IDLE: snk_ready=0; start=1 -> PACK, latch base_addr, clear lane index, pack register, and word_count.
REQ-022 PACK: snk_ready=1; each accepted byte goes to lane k, bits 8k+7:8k, little-endian, k=0..3, and k increments.
REQ-023 PACK: accepting the lane-3 byte or any byte with snk_eop=1 -> WRITE on the next edge.
REQ-024 WRITE lasts exactly one cycle: mem_chipselect=mem_write=1, snk_ready=0, mem_writedata=pack register, mem_byteenable=filled lanes (k bytes -> lower k bits set, e.g. 2 bytes -> 4'b0011).
REQ-025 Unfilled lanes of mem_writedata SHALL be 0.
REQ-026 Write latency: the byte completing a word is accepted at edge N; mem_write is high for cycle N..N+1 only.
REQ-027 After WRITE: the address increments, word_count increments, and k clears; the packet's last word -> DONE, otherwise -> PACK.
REQ-028 Address wrap: an increment from DEPTH-1 SHALL yield 0.
REQ-029 DONE lasts one cycle: done=1, busy=0 -> IDLE.
REQ-030 start outside IDLE SHALL be ignored; start and snk_valid arriving together in IDLE accept no byte that cycle.
REQ-031 snk_valid=0 in PACK holds all state; there is no timeout.
REQ-032 A bare eop with k=0 is impossible: eop always accompanies a byte, so a 4-byte-aligned packet writes exactly ceil(len/4) words.
REQ-033 mem_clken SHALL be constant 1; mem_chipselect and mem_write SHALL be low outside WRITE.

Reset
REQ-034 reset_n low SHALL immediately force IDLE and drive all outputs to 0, except mem_clken, which stays 1.
REQ-035 Reset mid-packet SHALL discard the partial word with no write issued; word_count returns to 0.
REQ-036 Release of reset SHALL be synchronised internally; the first active cycle is IDLE.

Configuration
REQ-037 Macro ONCHIP_STREAM_WRITER_CHECKSUM_EN defined: add output checksum[31:0], the modulo-2^32 sum of every mem_writedata written, with masked lanes counted as 0.
REQ-038 Under that macro, checksum clears on accepted start and on reset and is stable from DONE until the next start.
REQ-039 Macro undefined: no checksum port and no adder logic.

Verification
REQ-040 start with base_addr=0x0010, bytes 11,22,33,44 (eop on 44) -> one write: addr 0x0010, data 0x44332211, byteenable 4'hF; done after one cycle; word_count=1.
REQ-041 6-byte packet 01..06 at base 0 -> writes 0x04030201/4'hF at addr 0, then 0x00000605/4'h3 at addr 1; word_count=2.
REQ-042 base_addr=DEPTH-1 (11999), 8 bytes -> writes at 11999 then 0.
REQ-043 reset_n pulsed low after 2 bytes -> no mem_write; busy=0, word_count=0; a new start succeeds normally.
REQ-044 snk_valid toggled randomly and start re-pulsed mid-packet -> data identical to the continuous case; the second start is ignored.
REQ-045 CHECKSUM_EN defined, REQ-041 stimulus -> checksum=0x04030806.
